// File: rtl/tds_link_pkg.sv
// tds_link_pkg: link-state encoding, drop-counter width and default parameters for the link monitor.
package tds_link_pkg;
  typedef enum logic [1:0] {
    ST_DOWN    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_UP      = 2'd2,
    ST_LOST    = 2'd3
  } link_state_t;
  localparam int DROP_W            = 16;
  localparam int DEF_WINDOW_CYCLES = 160_000_000;
  localparam int DEF_LOCK_HOLD     = 1024;
  localparam int DEF_ERR_LIMIT     = 16;
  localparam int DEF_CNT_W         = 32;
endpackage

// File: rtl/tds_sat_counter.sv
// tds_sat_counter: saturating up-counter with synchronous clear that beats increment.
module tds_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk160,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk160 or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/tds_link_monitor.sv
// tds_link_monitor: qualifies strip-checker lock, counts frames/errors/drops and publishes windowed error rate.
module tds_link_monitor
  import tds_link_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int LOCK_HOLD     = DEF_LOCK_HOLD,
  parameter int ERR_LIMIT     = DEF_ERR_LIMIT,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic              clk160,
  input  logic              reset_n,
  input  logic              linked,
  input  logic              frame_valid,
  input  logic              frame_err,
  input  logic              clear,
  output logic [1:0]        link_state,
  output logic              link_up,
  output logic [CNT_W-1:0]  total_frames,
  output logic [CNT_W-1:0]  total_errs,
  output logic [DROP_W-1:0] link_drop_cnt,
  output logic [CNT_W-1:0]  window_errs,
  output logic              window_valid,
  output logic              degraded
);
  localparam int TW = $clog2(WINDOW_CYCLES);
  localparam int HW = $clog2(LOCK_HOLD) + 1;
  link_state_t state;
  logic [HW-1:0] hold;
  logic [TW-1:0] timer;
  logic [CNT_W-1:0] acc, win_next;
  logic up, fv_up, err_up, drop, tc;
  assign up         = state == ST_UP;
  assign fv_up      = up & frame_valid;
  assign err_up     = fv_up & frame_err;
  assign drop       = up & ~linked;
  assign tc         = timer == TW'(WINDOW_CYCLES - 1);
  assign win_next   = (&acc) ? acc : acc + CNT_W'(err_up);
  assign link_state = state;
  always_ff @(posedge clk160 or negedge reset_n)
    if (!reset_n) begin
      state   <= ST_DOWN;
      hold    <= '0;
      link_up <= 1'b0;
    end else begin
      case (state)
        ST_DOWN, ST_LOST:
          if (linked) begin
            state <= ST_ACQUIRE;
            hold  <= '0;
          end
        ST_ACQUIRE:
          if (!linked) begin
            state <= ST_DOWN;
            hold  <= '0;
          end else if (hold == HW'(LOCK_HOLD - 1)) begin
            state   <= ST_UP;
            link_up <= 1'b1;
          end else hold <= hold + 1'b1;
        ST_UP:
          if (!linked) begin
            state   <= ST_LOST;
            link_up <= 1'b0;
          end
      endcase
    end
  // Window latch includes this cycle's error; clear suppresses the latch entirely.
  always_ff @(posedge clk160 or negedge reset_n)
    if (!reset_n) begin
      timer        <= '0;
      window_errs  <= '0;
      window_valid <= 1'b0;
      degraded     <= 1'b0;
    end else if (clear) begin
      timer        <= '0;
      window_errs  <= '0;
      window_valid <= 1'b0;
      degraded     <= 1'b0;
    end else begin
      timer        <= tc ? '0 : timer + 1'b1;
      window_valid <= tc;
      if (tc) begin
        window_errs <= win_next;
        degraded    <= win_next >= CNT_W'(ERR_LIMIT);
      end
    end
  tds_sat_counter #(.W(CNT_W)) u_frames (
    .clk160(clk160), .reset_n(reset_n), .inc(fv_up), .clr(clear), .q(total_frames)
  );
  tds_sat_counter #(.W(CNT_W)) u_errs (
    .clk160(clk160), .reset_n(reset_n), .inc(err_up), .clr(clear), .q(total_errs)
  );
  tds_sat_counter #(.W(DROP_W)) u_drops (
    .clk160(clk160), .reset_n(reset_n), .inc(drop), .clr(clear), .q(link_drop_cnt)
  );
  tds_sat_counter #(.W(CNT_W)) u_acc (
    .clk160(clk160), .reset_n(reset_n), .inc(err_up), .clr(clear | tc), .q(acc)
  );
endmodule

// File: tb/tb_tds_link_monitor.sv
// tb_tds_link_monitor: directed table plus corner-case sequences for the link monitor (small parameters).
module tb_tds_link_monitor;
  logic        clk160 = 1'b0;
  logic        reset_n = 1'b0;
  logic        linked = 1'b0, frame_valid = 1'b0, frame_err = 1'b0, clear = 1'b0;
  logic [1:0]  link_state;
  logic        link_up, window_valid, degraded;
  logic [7:0]  total_frames, total_errs, window_errs;
  logic [15:0] link_drop_cnt;
  int cyc, checks, errors;

  typedef struct {int l, fv, fe, cl, st, fr, er, dr;} vec_t;
  vec_t tbl[23];

  tds_link_monitor #(.WINDOW_CYCLES(100), .LOCK_HOLD(4), .ERR_LIMIT(3), .CNT_W(8)) dut (
    .clk160(clk160), .reset_n(reset_n), .linked(linked), .frame_valid(frame_valid),
    .frame_err(frame_err), .clear(clear), .link_state(link_state), .link_up(link_up),
    .total_frames(total_frames), .total_errs(total_errs), .link_drop_cnt(link_drop_cnt),
    .window_errs(window_errs), .window_valid(window_valid), .degraded(degraded)
  );

  always #5 clk160 = ~clk160;

  task automatic tick();
    @(posedge clk160);
    #1;
    cyc++;
  endtask

  task automatic run_to(int n);
    while (cyc < n) tick();
  endtask

  task automatic one(string n, int act, int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d got %0d expected %0d", n, cyc, act, exp);
    end
  endtask

  task automatic chk_all(string t, int st, int fr, int er, int dr, int we, int wv, int dg);
    one({t, ":state"}, int'(link_state), st);
    one({t, ":link_up"}, int'(link_up), st < 0 ? -1 : int'(st == 2));
    one({t, ":frames"}, int'(total_frames), fr);
    one({t, ":errs"}, int'(total_errs), er);
    one({t, ":drops"}, int'(link_drop_cnt), dr);
    one({t, ":window_errs"}, int'(window_errs), we);
    one({t, ":window_valid"}, int'(window_valid), wv);
    one({t, ":degraded"}, int'(degraded), dg);
  endtask

  task automatic drive(int l, int fv, int fe, int cl);
    linked = l[0];
    frame_valid = fv[0];
    frame_err = fe[0];
    clear = cl[0];
  endtask

  initial begin
    //          l fv fe cl st fr er dr
    tbl[0]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 2, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 2, 1, 0, 0};
    tbl[6]  = '{1, 1, 1, 0, 2, 2, 1, 0};
    tbl[7]  = '{1, 0, 1, 0, 2, 2, 1, 0};
    tbl[8]  = '{0, 1, 1, 0, 3, 3, 2, 1};
    tbl[9]  = '{0, 1, 1, 0, 3, 3, 2, 1};
    tbl[10] = '{0, 0, 0, 0, 3, 3, 2, 1};
    tbl[11] = '{0, 0, 0, 0, 3, 3, 2, 1};
    tbl[12] = '{0, 0, 0, 0, 3, 3, 2, 1};
    tbl[13] = '{1, 0, 0, 0, 1, 3, 2, 1};
    tbl[14] = '{1, 0, 0, 0, 1, 3, 2, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 3, 2, 1};
    tbl[16] = '{1, 0, 0, 0, 1, 3, 2, 1};
    tbl[17] = '{1, 0, 0, 0, 1, 3, 2, 1};
    tbl[18] = '{1, 0, 0, 0, 1, 3, 2, 1};
    tbl[19] = '{1, 0, 0, 0, 1, 3, 2, 1};
    tbl[20] = '{1, 0, 0, 0, 2, 3, 2, 1};
    tbl[21] = '{1, 0, 0, 0, 2, 3, 2, 1};
    tbl[22] = '{1, 1, 1, 1, 2, 0, 0, 0};
    checks = 0;
    errors = 0;
    repeat (3) @(posedge clk160);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    run_to(99);
    chk_all("pre_win1", 0, -1, -1, -1, -1, 0, -1);
    tick();
    chk_all("win1", 0, 0, 0, 0, 0, 1, 0);
    tick();
    chk_all("post_win1", -1, -1, -1, -1, -1, 0, -1);
    run_to(110);
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].l, tbl[i].fv, tbl[i].fe, tbl[i].cl);
      tick();
      chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].fr, tbl[i].er, tbl[i].dr, 0, 0, 0);
    end
    drive(1, 0, 0, 0);
    // Clear at cycle 132 restarts the timer: terminal cycles are now 232, 332, ...
    run_to(200);
    drive(1, 1, 1, 0);
    tick();
    drive(1, 0, 0, 0);
    run_to(210);
    drive(1, 1, 1, 0);
    tick();
    drive(1, 0, 0, 0);
    run_to(232);
    chk_all("pre_term", 2, 2, 2, 0, 0, 0, 0);
    drive(1, 1, 1, 0);
    tick();
    drive(1, 0, 0, 0);
    chk_all("term_err", 2, 3, 3, 0, 3, 1, 1);
    tick();
    chk_all("after_term", 2, 3, 3, 0, 3, 0, 1);
    run_to(333);
    chk_all("quiet_win", 2, 3, 3, 0, 0, 1, 0);
    drive(1, 1, 0, 0);
    run_to(633);
    chk_all("saturate", 2, 255, 3, 0, 0, 1, 0);
    drive(0, 0, 0, 0);
    tick();
    chk_all("drop2", 3, 255, 3, 1, -1, -1, -1);
    drive(0, 1, 1, 0);
    run_to(644);
    chk_all("errs_not_up", 3, 255, 3, 1, -1, -1, -1);
    drive(1, 0, 0, 0);
    run_to(648);
    chk_all("reacq", 1, -1, -1, -1, -1, -1, -1);
    tick();
    chk_all("reup", 2, 255, 3, 1, -1, -1, -1);
    run_to(700);
    drive(1, 1, 1, 0);
    tick();
    tick();
    drive(1, 0, 0, 0);
    run_to(732);
    chk_all("pre_clear", 2, 255, 5, 1, 0, 0, 0);
    drive(1, 1, 1, 1);
    tick();
    drive(1, 0, 0, 0);
    chk_all("clear_coll", 2, 0, 0, 0, 0, 0, 0);
    run_to(832);
    chk_all("pre_win_clr", 2, 0, 0, 0, 0, 0, 0);
    tick();
    chk_all("win_after_clr", 2, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 0, 0);
    run_to(840);
    chk_all("pre_reset", 2, 7, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
